// File: rtl/token_access_arbiter_pkg.sv
// Shared types and helpers for the token access arbiter.
package access_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      CHECK   = 2'd1,
      GRANT   = 2'd2,
      RELEASE = 2'd3
   } state_t;

   localparam int unsigned DEF_TOKEN_W = 3;
   localparam int unsigned DEF_DATA_W  = 8;

   // Bits needed to index 'value' entries; never less than one.
   function automatic int unsigned clog2(input int unsigned value);
      int unsigned w;
      w = 1;
      while ((64'd1 << w) < 64'(value)) w = w + 1;
      return w;
   endfunction

endpackage

// File: rtl/token_access_arbiter_if.sv
// Requester-side and controller-side signals of the token access arbiter.
interface token_access_arbiter_if #(
   parameter int unsigned NUM_USERS = 4,
   parameter int unsigned TOKEN_W   = 3,
   parameter int unsigned DATA_W    = 8
);
   logic [TOKEN_W-1:0]           system_token;
   logic [NUM_USERS-1:0]         req;
   logic [NUM_USERS*TOKEN_W-1:0] user_token;
   logic [NUM_USERS*DATA_W-1:0]  user_data;
   logic [NUM_USERS-1:0]         user_done;
   logic [NUM_USERS-1:0]         grant;
   logic [NUM_USERS-1:0]         denied;
   logic [NUM_USERS-1:0]         locked;
   logic                         busy;
   logic                         ctl_request;
   logic                         ctl_confirm;
   logic [TOKEN_W-1:0]           ctl_user_token;
   logic [DATA_W-1:0]            ctl_TimeData;

   modport master (
      output system_token, req, user_token, user_data, user_done,
      input  grant, denied, locked, busy,
      input  ctl_request, ctl_confirm, ctl_user_token, ctl_TimeData
   );

   modport slave (
      input  system_token, req, user_token, user_data, user_done,
      output grant, denied, locked, busy,
      output ctl_request, ctl_confirm, ctl_user_token, ctl_TimeData
   );
endinterface

// File: rtl/token_access_arbiter_rr_pick.sv
// Round-robin first-one search over 'eligible', starting just after 'last'.
module rr_pick #(
   parameter int unsigned N     = 4,
   parameter int unsigned IDX_W = 2
) (
   input  logic [N-1:0]     eligible,
   input  logic [IDX_W-1:0] last,
   output logic [IDX_W-1:0] idx_c,
   output logic             valid_c
);

   logic [IDX_W-1:0] pos;

   always_comb begin
      idx_c   = '0;
      valid_c = 1'b0;
      pos     = '0;
      for (int unsigned k = 1; k <= N; k++) begin
         pos = IDX_W'((32'(last) + k) % N);
         if (!valid_c && eligible[pos]) begin
            valid_c = 1'b1;
            idx_c   = pos;
         end
      end
   end

endmodule

// File: rtl/token_access_arbiter.sv
// Round-robin arbiter that token-checks one requester at a time and forwards it
// to the shared controller; repeated token failures lock a requester out.
module token_access_arbiter
   import access_pkg::*;
#(
   parameter int unsigned NUM_USERS      = 4,
   parameter int unsigned TOKEN_W        = DEF_TOKEN_W,
   parameter int unsigned DATA_W         = DEF_DATA_W,
   parameter int unsigned MAX_FAILS      = 3,
   parameter int unsigned LOCKOUT_CYCLES = 16,
   parameter int unsigned HOLD_MAX       = 32
) (
   input logic                  clock,
   input logic                  reset,
   token_access_arbiter_if.slave bus
);

   localparam int unsigned IDX_W  = clog2(NUM_USERS);
   localparam int unsigned FAIL_W = clog2(MAX_FAILS + 1);
   localparam int unsigned LOCK_W = clog2(LOCKOUT_CYCLES + 1);
   localparam int unsigned HOLD_W = clog2(HOLD_MAX);

   state_t               state, state_nxt;
   logic [IDX_W-1:0]     sel, sel_nxt, last, last_nxt, pick_idx_c;
   logic                 pick_valid_c;
   logic [HOLD_W-1:0]    hold_cnt, hold_nxt;
   logic [NUM_USERS-1:0] eligible_c, sel_onehot_c, locked_q;
   logic [NUM_USERS-1:0] grant_nxt, denied_nxt;
   logic                 busy_nxt, request_nxt, confirm_nxt, token_ok_c;
   logic [TOKEN_W-1:0]   ctl_token_nxt;
   logic [DATA_W-1:0]    ctl_data_nxt;
   logic [TOKEN_W-1:0]   tok_arr  [NUM_USERS];
   logic [DATA_W-1:0]    data_arr [NUM_USERS];

   assign eligible_c   = bus.req & ~locked_q;
   assign sel_onehot_c = NUM_USERS'(1) << sel;
   assign token_ok_c   = (tok_arr[sel] == bus.system_token);
   assign bus.locked   = locked_q;

   rr_pick #(
      .N     (NUM_USERS),
      .IDX_W (IDX_W)
   ) u_pick (
      .eligible (eligible_c),
      .last     (last),
      .idx_c    (pick_idx_c),
      .valid_c  (pick_valid_c)
   );

   // Per-user operand slicing plus fail and lockout bookkeeping.
   for (genvar i = 0; i < NUM_USERS; i++) begin : g_user
      logic [FAIL_W-1:0] fail_cnt;
      logic [LOCK_W-1:0] lock_cnt;
      logic              lock_bit;
      logic              check_here_c;

      assign tok_arr[i]   = bus.user_token[i*TOKEN_W +: TOKEN_W];
      assign data_arr[i]  = bus.user_data[i*DATA_W +: DATA_W];
      assign check_here_c = (state == CHECK) && (sel == IDX_W'(i));
      assign locked_q[i]  = lock_bit;

      always_ff @(posedge clock) begin
         if (reset) begin
            fail_cnt <= '0;
            lock_cnt <= '0;
            lock_bit <= 1'b0;
         end else begin
            if (lock_cnt != '0) begin
               lock_cnt <= lock_cnt - LOCK_W'(1);
               if (lock_cnt == LOCK_W'(1)) lock_bit <= 1'b0;
            end
            if (check_here_c) begin
               if (token_ok_c) begin
                  fail_cnt <= '0;
               end else if (fail_cnt == FAIL_W'(MAX_FAILS - 1)) begin
                  fail_cnt <= '0;
                  lock_bit <= 1'b1;
                  lock_cnt <= LOCK_W'(LOCKOUT_CYCLES);
               end else begin
                  fail_cnt <= fail_cnt + FAIL_W'(1);
               end
            end
         end
      end
   end

   always_ff @(posedge clock) begin
      if (reset) state <= IDLE;
      else       state <= state_nxt;
   end

   always_comb begin
      state_nxt     = state;
      sel_nxt       = sel;
      last_nxt      = last;
      hold_nxt      = hold_cnt;
      grant_nxt     = bus.grant;
      denied_nxt    = '0;
      request_nxt   = bus.ctl_request;
      confirm_nxt   = bus.ctl_confirm;
      ctl_token_nxt = bus.ctl_user_token;
      ctl_data_nxt  = bus.ctl_TimeData;
      case (state)
         IDLE: begin
            if (pick_valid_c) begin
               sel_nxt   = pick_idx_c;
               state_nxt = CHECK;
            end
         end
         CHECK: begin
            if (token_ok_c) begin
               grant_nxt   = sel_onehot_c;
               request_nxt = 1'b1;
               confirm_nxt = 1'b1;
               hold_nxt    = '0;
               state_nxt   = GRANT;
            end else begin
               denied_nxt = sel_onehot_c;
               last_nxt   = sel;
               state_nxt  = IDLE;
            end
         end
         GRANT: begin
            // Token is only checked once; later values are forwarded as-is.
            ctl_token_nxt = tok_arr[sel];
            ctl_data_nxt  = data_arr[sel];
            hold_nxt      = hold_cnt + HOLD_W'(1);
            if (bus.user_done[sel] || !bus.req[sel] ||
                (hold_cnt == HOLD_W'(HOLD_MAX - 1))) begin
               state_nxt = RELEASE;
            end
         end
         RELEASE: begin
            grant_nxt     = '0;
            request_nxt   = 1'b0;
            confirm_nxt   = 1'b0;
            ctl_token_nxt = '0;
            ctl_data_nxt  = '0;
            last_nxt      = sel;
            state_nxt     = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
      busy_nxt = (state_nxt != IDLE);
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         sel                <= '0;
         last               <= IDX_W'(NUM_USERS - 1);
         hold_cnt           <= '0;
         bus.grant          <= '0;
         bus.denied         <= '0;
         bus.busy           <= 1'b0;
         bus.ctl_request    <= 1'b0;
         bus.ctl_confirm    <= 1'b0;
         bus.ctl_user_token <= '0;
         bus.ctl_TimeData   <= '0;
      end else begin
         sel                <= sel_nxt;
         last               <= last_nxt;
         hold_cnt           <= hold_nxt;
         bus.grant          <= grant_nxt;
         bus.denied         <= denied_nxt;
         bus.busy           <= busy_nxt;
         bus.ctl_request    <= request_nxt;
         bus.ctl_confirm    <= confirm_nxt;
         bus.ctl_user_token <= ctl_token_nxt;
         bus.ctl_TimeData   <= ctl_data_nxt;
      end
   end

endmodule

// File: tb/tb_token_access_arbiter.sv
// Directed scenarios plus randomized traffic against a cycle reference model.
module tb_token_access_arbiter;

   localparam int unsigned N     = 4;
   localparam int unsigned TW    = 3;
   localparam int unsigned DW    = 8;
   localparam int unsigned MAXF  = 3;
   localparam int unsigned LOCKC = 16;
   localparam int unsigned HOLDM = 32;

   localparam int P_IDLE = 0, P_CHECK = 1, P_GRANT = 2, P_RELEASE = 3;

   logic clock = 1'b0;
   logic reset;
   always #5 clock = ~clock;

   token_access_arbiter_if #(.NUM_USERS(N), .TOKEN_W(TW), .DATA_W(DW)) bus ();

   token_access_arbiter #(
      .NUM_USERS(N), .TOKEN_W(TW), .DATA_W(DW),
      .MAX_FAILS(MAXF), .LOCKOUT_CYCLES(LOCKC), .HOLD_MAX(HOLDM)
   ) dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus)
   );

   int n_tests = 0;
   int n_fail  = 0;
   int cyc     = 0;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s (cycle %0d): got %0h expected %0h", tag, cyc, got, exp);
      end
   endtask

   // Reference model state, expressed in terms of arbitration phases.
   int m_phase, m_sel, m_last, m_held;
   int m_fail    [N];
   int m_lockleft[N];
   logic [N-1:0]  e_grant, e_denied;
   logic          e_creq, e_conf;
   logic [TW-1:0] e_tok;
   logic [DW-1:0] e_data;

   function automatic logic [TW-1:0] tok_of(input int i);
      logic [N*TW-1:0] v;
      v = bus.user_token;
      return v[i*TW +: TW];
   endfunction

   function automatic logic [DW-1:0] data_of(input int i);
      logic [N*DW-1:0] v;
      v = bus.user_data;
      return v[i*DW +: DW];
   endfunction

   task automatic model_step();
      logic [N-1:0] locked_before;
      if (reset) begin
         m_phase = P_IDLE; m_sel = 0; m_last = N - 1; m_held = 0;
         for (int i = 0; i < N; i++) begin m_fail[i] = 0; m_lockleft[i] = 0; end
         e_grant = '0; e_denied = '0; e_creq = 1'b0; e_conf = 1'b0;
         e_tok = '0; e_data = '0;
         return;
      end
      for (int i = 0; i < N; i++) begin
         locked_before[i] = (m_lockleft[i] > 0);
         if (m_lockleft[i] > 0) m_lockleft[i]--;
      end
      e_denied = '0;
      case (m_phase)
         P_IDLE: begin
            for (int k = 1; k <= N; k++) begin
               int u;
               u = (m_last + k) % N;
               if (bus.req[u] && !locked_before[u]) begin
                  m_sel = u; m_phase = P_CHECK; break;
               end
            end
         end
         P_CHECK: begin
            if (tok_of(m_sel) == bus.system_token) begin
               m_fail[m_sel] = 0;
               e_grant = '0; e_grant[m_sel] = 1'b1;
               e_creq = 1'b1; e_conf = 1'b1;
               m_held = 0; m_phase = P_GRANT;
            end else begin
               e_denied[m_sel] = 1'b1;
               m_fail[m_sel]++;
               if (m_fail[m_sel] == MAXF) begin
                  m_lockleft[m_sel] = LOCKC;
                  m_fail[m_sel] = 0;
               end
               m_last = m_sel; m_phase = P_IDLE;
            end
         end
         P_GRANT: begin
            e_tok  = tok_of(m_sel);
            e_data = data_of(m_sel);
            m_held++;
            if (bus.user_done[m_sel] || !bus.req[m_sel] || m_held == HOLDM) m_phase = P_RELEASE;
         end
         default: begin
            e_grant = '0; e_creq = 1'b0; e_conf = 1'b0; e_tok = '0; e_data = '0;
            m_last = m_sel; m_phase = P_IDLE;
         end
      endcase
   endtask

   task automatic compare_all();
      logic [N-1:0] e_locked;
      for (int i = 0; i < N; i++) e_locked[i] = (m_lockleft[i] > 0);
      check("grant",       bus.grant,          e_grant);
      check("denied",      bus.denied,         e_denied);
      check("locked",      bus.locked,         e_locked);
      check("busy",        bus.busy,           m_phase != P_IDLE);
      check("ctl_request", bus.ctl_request,    e_creq);
      check("ctl_confirm", bus.ctl_confirm,    e_conf);
      check("ctl_token",   bus.ctl_user_token, e_tok);
      check("ctl_data",    bus.ctl_TimeData,   e_data);
   endtask

   task automatic tick();
      @(posedge clock);
      model_step();
      #1;
      compare_all();
      cyc++;
   endtask

   task automatic set_user(input int i, input logic r, input logic [TW-1:0] t, input logic [DW-1:0] d);
      bus.req[i] = r;
      bus.user_token[i*TW +: TW] = t;
      bus.user_data[i*DW +: DW] = d;
   endtask

   task automatic settle();
      bus.req = '0;
      bus.user_done = '0;
      repeat (8) tick();
   endtask

   task automatic do_reset();
      reset = 1'b1;
      repeat (2) tick();
      reset = 1'b0;
   endtask

   initial begin
      int order[$];
      int gcyc[N];
      logic [N-1:0] prev;
      int cnt_a, cnt_b;
      logic flag;
      logic [N-1:0] first_other;

      reset = 1'b1;
      bus.system_token = '0; bus.req = '0; bus.user_token = '0;
      bus.user_data = '0; bus.user_done = '0;
      repeat (3) tick();
      check("reset_grant", bus.grant, '0);
      reset = 1'b0;

      // Single grant
      bus.system_token = 3'b101;
      set_user(0, 1'b1, 3'b101, 8'hF2);
      tick();
      tick();
      check("sg_grant", bus.grant, 4'b0001);
      check("sg_confirm", bus.ctl_confirm, 1'b1);
      tick();
      check("sg_data", bus.ctl_TimeData, 8'hF2);
      bus.user_done[0] = 1'b1;
      tick();
      bus.user_done = '0; bus.req = '0;
      tick();
      check("sg_drop", bus.grant, '0);
      settle();

      // Round robin between users 0 and 2
      do_reset();
      set_user(0, 1'b1, 3'b101, 8'h11);
      set_user(2, 1'b1, 3'b101, 8'h22);
      for (int i = 0; i < N; i++) gcyc[i] = 0;
      prev = '0;
      for (int c = 0; c < 80 && order.size() < 4; c++) begin
         tick();
         for (int i = 0; i < N; i++) begin
            if (bus.grant[i] && !prev[i]) order.push_back(i);
            gcyc[i] = e_grant[i] ? gcyc[i] + 1 : 0;
            bus.user_done[i] = e_grant[i] && (gcyc[i] >= 3);
         end
         prev = bus.grant;
      end
      check("rr_count", order.size(), 4);
      for (int k = 0; k < order.size(); k++) check("rr_order", order[k], (k % 2 == 0) ? 0 : 2);
      settle();

      // Lockout of user 1
      set_user(1, 1'b1, 3'b000, 8'h33);
      cnt_a = 0; cnt_b = 0; flag = 1'b0;
      for (int c = 0; c < 60 && !flag; c++) begin
         tick();
         if (bus.denied[1]) cnt_a++;
         if (bus.locked[1]) begin
            cnt_b++;
            bus.user_token[1*TW +: TW] = 3'b101;
         end
         if (bus.grant[1]) flag = 1'b1;
      end
      check("lock_denials", cnt_a, 3);
      check("lock_cycles", cnt_b, LOCKC);
      check("lock_then_grant", flag, 1'b1);
      settle();

      // Hold timeout for user 3, user 0 joins later
      set_user(3, 1'b1, 3'b101, 8'h44);
      cnt_a = 0; flag = 1'b0; first_other = '0;
      for (int c = 0; c < 90 && first_other == '0; c++) begin
         tick();
         if (c == 5) set_user(0, 1'b1, 3'b101, 8'h55);
         if (bus.grant[3] && !flag) cnt_a++;
         if (cnt_a > 0 && !bus.grant[3]) flag = 1'b1;
         if (flag && bus.grant != '0 && !bus.grant[3]) first_other = bus.grant;
      end
      // Grant stays visible through the RELEASE cycle after HOLD_MAX GRANT cycles
      check("timeout_len", cnt_a, HOLDM + 1);
      check("after_timeout", first_other, 4'b0001);
      settle();

      // Reset while user 2 holds the grant
      set_user(2, 1'b1, 3'b101, 8'h66);
      flag = 1'b0;
      for (int c = 0; c < 12 && !flag; c++) begin
         tick();
         if (bus.grant == 4'b0100) flag = 1'b1;
      end
      check("mid_grant_seen", flag, 1'b1);
      reset = 1'b1;
      tick();
      check("rst_grant", bus.grant, '0);
      check("rst_busy", bus.busy, 1'b0);
      check("rst_request", bus.ctl_request, 1'b0);
      reset = 1'b0;
      for (int i = 0; i < N; i++) set_user(i, 1'b1, 3'b101, DW'(i));
      first_other = '0;
      for (int c = 0; c < 10 && first_other == '0; c++) begin
         tick();
         first_other = bus.grant;
      end
      check("rst_first_user", first_other, 4'b0001);
      settle();

      // Done, req drop and timeout all on the same edge
      set_user(1, 1'b1, 3'b101, 8'h77);
      flag = 1'b0;
      for (int c = 0; c < 80 && !flag; c++) begin
         tick();
         if (m_phase == P_GRANT && m_held == HOLDM - 1) flag = 1'b1;
      end
      check("simul_reach", flag, 1'b1);
      bus.user_done[1] = 1'b1; bus.req[1] = 1'b0;
      cnt_a = 0; cnt_b = 0;
      for (int c = 0; c < 6; c++) begin
         tick();
         if (bus.denied != '0) cnt_a++;
         if (bus.busy) cnt_b++;
         bus.user_done = '0;
      end
      check("simul_no_denied", cnt_a, 0);
      check("simul_release_once", cnt_b, 1);
      settle();

      // Randomized traffic
      for (int c = 0; c < 3000; c++) begin
         reset = ($urandom_range(0, 249) == 0);
         if ($urandom_range(0, 49) == 0) bus.system_token = TW'($urandom);
         for (int i = 0; i < N; i++) begin
            if ($urandom_range(0, 4) == 0) bus.req[i] = ~bus.req[i];
            bus.user_token[i*TW +: TW] = ($urandom_range(0, 3) == 0) ? TW'($urandom) : bus.system_token;
            bus.user_data[i*DW +: DW] = DW'($urandom);
            bus.user_done[i] = ($urandom_range(0, 9) == 0);
         end
         tick();
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/token_access_arbiter.md
# token_access_arbiter

Shares the single token-authenticated `controller` between `NUM_USERS` requesters. Each requester presents a request, a 3-bit user token and an 8-bit time value. The arbiter picks one requester round-robin and checks its token against `system_token`. On a match it drives the controller's `request`/`confirm`/`user_token`/`TimeData` inputs for that requester. Repeated token failures lock a requester out for a fixed number of cycles.

## Interface
- `NUM_USERS`, 4, number of requesters (≥2)
- `TOKEN_W`, 3, token width
- `DATA_W`, 8, time-data width
- `MAX_FAILS`, 3, consecutive mismatches that trigger lockout (≥1)
- `LOCKOUT_CYCLES`, 16, lockout duration in cycles (≥1)
- `HOLD_MAX`, 32, maximum cycles a grant may be held (≥1)

Ports:
- `clock` in 1: single clock, rising edge
- `reset` in 1: synchronous, active-high
- `system_token` in `TOKEN_W`: reference token
- `req` in `NUM_USERS`: per-user request level
- `user_token` in `NUM_USERS*TOKEN_W`: user i at `[i*TOKEN_W +: TOKEN_W]`
- `user_data` in `NUM_USERS*DATA_W`: user i at `[i*DATA_W +: DATA_W]`
- `user_done` in `NUM_USERS`: granted user releases
- `grant` out `NUM_USERS`: one-hot or zero
- `denied` out `NUM_USERS`: one-cycle pulse on token mismatch
- `locked` out `NUM_USERS`: user in lockout
- `busy` out 1: state ≠ IDLE
- `ctl_request`, `ctl_confirm` out 1: to controller
- `ctl_user_token` out `TOKEN_W`, `ctl_TimeData` out `DATA_W`: to controller

## Operation
- **Outputs.** All outputs are registered. Reset value of every output is 0.
- **Reset.** Clears all fail counters and lockout counters. Sets the round-robin pointer `last` to `NUM_USERS-1`, so user 0 has first priority.
- **Eligibility.** `eligible = req & ~locked`.
- **FSM states:** IDLE, CHECK, GRANT, RELEASE.
- **IDLE.**
  - If `eligible` ≠ 0, select the first eligible index searching from `last+1` with wrap. Register it as `sel` and go to CHECK.
  - Otherwise stay in IDLE.
- **CHECK.** Lasts one cycle. Compares `user_token[sel]` with `system_token`.
  - On match:
    - clear `fail_cnt[sel]`
    - set `grant[sel]`, `ctl_request`, `ctl_confirm`
    - clear the hold counter
    - go to GRANT
  - On mismatch:
    - pulse `denied[sel]` and increment `fail_cnt[sel]`
    - if the count reaches `MAX_FAILS`, set `locked[sel]`, load `lock_cnt[sel]=LOCKOUT_CYCLES` and clear `fail_cnt[sel]`
    - set `last=sel` and go to IDLE
- **GRANT.**
  - Each cycle, register `user_token[sel]` to `ctl_user_token` and `user_data[sel]` to `ctl_TimeData`.
  - The token is checked only once; later token changes are forwarded but not re-checked.
  - The hold counter increments each cycle.
  - Exit to RELEASE when `user_done[sel]`, or `!req[sel]`, or hold counter = `HOLD_MAX-1`. Any combination of these on the same cycle gives the same result.
- **RELEASE.** Lasts one cycle.
  - Clear `grant`, `ctl_*`, `ctl_TimeData` and `ctl_user_token` to 0.
  - Set `last=sel` and go to IDLE.
- **Lockout counters.** Each nonzero `lock_cnt[i]` decrements every cycle. When it reaches 1, `locked[i]` clears on the next edge. Decrementing is independent of FSM state.
- **Mid-operation reset.** A reset asserted in any state returns the FSM to IDLE with all outputs 0 at the next edge.

## Timing
- **Grant latency.**
  - `req[i]` high before edge E0 in IDLE gives CHECK after E0.
  - `grant[i]`, `ctl_request` and `ctl_confirm` are high after E1.
  - `ctl_user_token` and `ctl_TimeData` are valid after E2.
- **Release latency.** `user_done` sampled at edge En causes `grant` to drop after En+1. The earliest next CHECK follows after En+2.
- **Denial latency.** `denied` is high for exactly one cycle, after the CHECK edge. `locked` rises on the same edge.
- **Timeout.** With `req` held, a user holds the grant for at most `HOLD_MAX` cycles, then must re-arbitrate.
- **Lockout duration.** `locked` stays high for exactly `LOCKOUT_CYCLES` cycles.

## Structure
- Shared package `access_pkg` holds:
  - the FSM state enum (IDLE/CHECK/GRANT/RELEASE)
  - default `TOKEN_W`/`DATA_W`
  - a `clog2` helper for counter widths
- Sub-module `rr_pick`: combinational round-robin first-one search over `eligible` starting at `last+1`. Outputs index and valid.
- Fail and lockout counters stay inline, one generate loop per user.

## Test plan
- **Single grant.** `system_token=3'b101`, user 0 `req=1`, token `3'b101`, data `8'hF2`. Expect `grant=4'b0001` two edges later, and `ctl_TimeData=8'hF2`, `ctl_confirm=1`.
- **Round-robin.** Users 0 and 2 request continuously with correct tokens and assert `user_done` after 3 cycles. Expect grants in order 0, 2, 0, 2, with one RELEASE cycle between each.
- **Lockout.** User 1 uses token `3'b000` three times. Expect three `denied[1]` pulses, then `locked[1]=1` for 16 cycles while `req[1]` is ignored. After that, user 1 is granted with the correct token.
- **Hold timeout.** User 3 holds `req` without `user_done`. Expect `grant[3]` to drop after 32 GRANT cycles. User 0 is then granted if requesting, otherwise user 3 is re-checked.
- **Reset mid-GRANT.** Assert `reset` while `grant=4'b0100`. Expect all outputs 0 next edge. Next arbitration then starts from user 0.
- **Simultaneous release.** `user_done` and `req` drop together with timeout on the same cycle. Expect a single RELEASE cycle and no spurious `denied`.
